// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit BCD adder sequencer: streams packed operands through a shared
// one-digit BCD adder, LSD first, chaining the decimal carry between digits.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic [3:0]            dig_a,
    output logic [3:0]            dig_b,
    output logic                  dig_cin,
    input  logic [3:0]            dig_sum,
    input  logic                  dig_cout,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [4*DIGITS-1:0] a_reg;
    logic [4*DIGITS-1:0] b_reg;
    logic [4*DIGITS-1:0] sum_reg;
    logic                carry_reg;
    logic                cout_reg;
    logic                err_reg;
    logic [IW-1:0]       idx;
    logic                accept;
    logic                last;
    logic                bad;
    int unsigned         pos;

    assign accept = start && (state != ADD);
    assign last   = (idx == LAST);
    assign pos    = 32'(idx) * 4;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i+:4] > 4'd9 || b[4*i+:4] > 4'd9) begin
                bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        dig_a    = '0;
        dig_b    = '0;
        dig_cin  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = ADD;
            end
            ADD: begin
                dig_a   = a_reg[pos+:4];
                dig_b   = b_reg[pos+:4];
                dig_cin = carry_reg;
                if (last) state_nx = DONE;
            end
            DONE: begin
                state_nx = accept ? ADD : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            err_reg   <= 1'b0;
            idx       <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= cin;
                idx       <= '0;
                sum_reg   <= '0;
                cout_reg  <= 1'b0;
                err_reg   <= bad;
            end else if (state == ADD) begin
                carry_reg <= dig_cout;
                if (last) begin
                    // An invalid operand still runs to completion but
                    // reports an all-zero result.
                    if (err_reg) begin
                        sum_reg  <= '0;
                        cout_reg <= 1'b0;
                    end else begin
                        sum_reg[pos+:4] <= dig_sum;
                        cout_reg        <= dig_cout;
                    end
                end else begin
                    sum_reg[pos+:4] <= dig_sum;
                    idx             <= idx + 1'b1;
                end
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign err  = err_reg;
    assign busy = (state == ADD);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl: directed cases plus random
// BCD operands against a decimal-arithmetic reference model.
module tb_bcd_serial_add_ctrl;

    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4*D-1:0] a;
    logic [4*D-1:0] b;
    logic          cin;
    logic [3:0]    dig_a;
    logic [3:0]    dig_b;
    logic          dig_cin;
    logic [3:0]    dig_sum;
    logic          dig_cout;
    logic [4*D-1:0] sum;
    logic          cout;
    logic          busy;
    logic          done;
    logic          err;

    int checks   = 0;
    int failures = 0;

    bcd_serial_add_ctrl #(.DIGITS(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .dig_a    (dig_a),
        .dig_b    (dig_b),
        .dig_cin  (dig_cin),
        .dig_sum  (dig_sum),
        .dig_cout (dig_cout),
        .sum      (sum),
        .cout     (cout),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Behavioural one-digit BCD adder standing in for the external datapath.
    always_comb begin
        logic [4:0] s;
        s = 5'(dig_a) + 5'(dig_b) + 5'(dig_cin);
        if (s > 5'd9) begin
            dig_sum  = 4'(s - 5'd10);
            dig_cout = 1'b1;
        end else begin
            dig_sum  = s[3:0];
            dig_cout = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int digit(input logic [4*D-1:0] v, input int i);
        logic [4*D-1:0] t;
        t = v >> (4 * i);
        return int'(t[3:0]);
    endfunction

    // Decimal value of the lowest n digits.
    function automatic int low_val(input logic [4*D-1:0] v, input int n);
        int r = 0;
        int p = 1;
        for (int i = 0; i < n; i++) begin
            r += digit(v, i) * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p *= 10;
        return p;
    endfunction

    function automatic logic is_bad(input logic [4*D-1:0] xa,
                                    input logic [4*D-1:0] xb);
        logic e = 1'b0;
        for (int i = 0; i < D; i++)
            if (digit(xa, i) > 9 || digit(xb, i) > 9) e = 1'b1;
        return e;
    endfunction

    task automatic model(input logic [4*D-1:0] xa, input logic [4*D-1:0] xb,
                         input logic xc, output logic [4*D-1:0] s,
                         output logic c, output logic e);
        int t;
        e = is_bad(xa, xb);
        t = low_val(xa, D) + low_val(xb, D) + int'(xc);
        c = (t >= pow10(D));
        t = t % pow10(D);
        s = '0;
        for (int i = 0; i < D; i++) begin
            s[4*i+:4] = 4'(t % 10);
            t = t / 10;
        end
        if (e) begin
            s = '0;
            c = 1'b0;
        end
    endtask

    // Called at a negedge in IDLE or DONE; returns at the negedge where done is seen.
    task automatic run(input logic [4*D-1:0] xa, input logic [4*D-1:0] xb,
                       input logic xc, input bit poke);
        logic [4*D-1:0] es;
        logic           ec;
        logic           ee;
        logic [3:0]     la [8];
        logic [3:0]     lb [8];
        logic           lc [8];
        int             k;
        int             nb;
        int             ecin;
        model(xa, xb, xc, es, ec, ee);
        a = xa;
        b = xb;
        cin = xc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        nb = 0;
        while (!done && k < 12) begin
            if (busy && nb < 8) begin
                la[nb] = dig_a;
                lb[nb] = dig_b;
                lc[nb] = dig_cin;
                nb++;
            end
            if (poke && k == 2) begin
                start = 1'b1;
                a = ~xa;
                b = ~xb;
                cin = ~xc;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("latency", 32'(k), 32'd5);
        check("busy_cycles", 32'(nb), 32'(D));
        check("sum", 32'(sum), 32'(es));
        check("cout", 32'(cout), 32'(ec));
        check("err", 32'(err), 32'(ee));
        check("dig_idle", {23'd0, dig_a, dig_b, dig_cin}, 32'd0);
        if (nb == D) begin
            for (int i = 0; i < D; i++) begin
                check("dig_a", 32'(la[i]), 32'(digit(xa, i)));
                check("dig_b", 32'(lb[i]), 32'(digit(xb, i)));
                if (!ee) begin
                    ecin = (low_val(xa, i) + low_val(xb, i) + int'(xc)
                            >= pow10(i)) ? 1 : 0;
                    if (i == 0) ecin = int'(xc);
                    check("dig_cin", 32'(lc[i]), 32'(ecin));
                end
            end
        end
    endtask

    task automatic settle_idle();
        logic [4*D-1:0] hs;
        hs = sum;
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("sum_hold", 32'(sum), 32'(hs));
    endtask

    function automatic logic [4*D-1:0] rand_bcd();
        logic [4*D-1:0] v;
        for (int i = 0; i < D; i++) v[4*i+:4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        logic [4*D-1:0] ra;
        logic [4*D-1:0] rb;
        int             nd;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        #1;
        check("rst_outs", {sum, cout, busy, done, err, dig_a, dig_b, dig_cin},
              32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run(16'h1234, 16'h5678, 1'b0, 1'b0);
        settle_idle();
        run(16'h9999, 16'h0001, 1'b0, 1'b0);
        settle_idle();
        run(16'h0000, 16'h0000, 1'b1, 1'b0);
        settle_idle();
        run(16'h9999, 16'h9999, 1'b1, 1'b0);
        settle_idle();
        run(16'h12A4, 16'h0001, 1'b0, 1'b0);
        settle_idle();
        check("err_hold", 32'(err), 32'd1);
        run(16'h0005, 16'h0005, 1'b0, 1'b0);
        settle_idle();

        run(16'h1234, 16'h5678, 1'b0, 1'b1);
        // Back-to-back: each run starts in the DONE cycle of the previous.
        run(16'h0042, 16'h0958, 1'b0, 1'b0);
        run(16'h1234, 16'h5678, 1'b1, 1'b0);
        settle_idle();

        // Reset two cycles into ADD.
        a = 16'h1234;
        b = 16'h5678;
        cin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("partial_sum", 32'(sum), 32'h0002);
        rst = 1'b1;
        #1;
        check("rst_abort",
              {sum, cout, busy, done, err, dig_a, dig_b, dig_cin}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        check("no_done_after_rst", 32'(nd), 32'd0);
        run(16'h0005, 16'h0007, 1'b0, 1'b0);
        settle_idle();

        for (int n = 0; n < 30; n++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            if ($urandom_range(0, 9) == 0)
                ra[4*$urandom_range(0, D-1)+:4] = 4'($urandom_range(10, 15));
            run(ra, rb, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) settle_idle();
        end
        settle_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_serial_add_ctrl.md
# bcd_serial_add_ctrl

Sequencer for multi-digit BCD addition using a single shared one-digit BCD adder (4-bit a/b, cin → 4-bit sum, cout). It captures two DIGITS-wide packed BCD operands on a start strobe, then feeds them through the external digit adder one digit per clock, least-significant digit first. It chains the carry between digits and assembles the packed result, with a busy/done handshake and an invalid-digit flag. It sits between the lab top-level (switch or test-driver inputs) and the existing digit-adder datapath.

## Interface
- DIGITS, default 4: number of BCD digits per operand; legal range 1..8.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request strobe; sampled only in IDLE or DONE.
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
- b  input  4*DIGITS  operand B, same packing.
- cin  input  1  carry into digit 0.
- dig_a  output  4  to digit adder: current A digit.
- dig_b  output  4  to digit adder: current B digit.
- dig_cin  output  1  to digit adder: current carry.
- dig_sum  input  4  from digit adder: corrected digit sum (combinational from dig_*).
- dig_cout  input  1  from digit adder: decimal carry out.
- sum  output  4*DIGITS  registered packed BCD result.
- cout  output  1  registered decimal carry out of the top digit.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse: result valid.
- err  output  1  registered; set when any captured operand digit is greater than 9.

## Operation
- States: IDLE, ADD, DONE. Reset state is IDLE.
- IDLE, start=1: capture a, b, and cin into a_reg, b_reg, and carry_reg. Clear idx to 0 and sum_reg to 0. Compute err from the captured digits. Go to ADD.
- ADD: dig_a = a_reg[4*idx+:4], dig_b = b_reg[4*idx+:4], dig_cin = carry_reg. Each edge does the following:
  - sum_reg[4*idx+:4] <= dig_sum
  - carry_reg <= dig_cout
  - idx <= idx+1
  - on the edge where idx == DIGITS-1, go to DONE instead of incrementing.
- DONE: done=1 for exactly this cycle. cout = carry_reg. Next state is ADD if start=1 (operands recaptured, back-to-back), otherwise IDLE.
- start during ADD is ignored; there is no queuing.
- sum, cout, and err hold their values from DONE until the next accepted start, which clears sum and cout to 0.
- err=1: the computation still runs, but on entry to DONE, sum and cout are forced to 0. err stays high until the next accepted start.
- dig_a, dig_b, and dig_cin are 0 in IDLE and DONE.
- The idx width is clog2(DIGITS) bits, minimum 1. idx never wraps past DIGITS-1.

## Timing
- Reset (asynchronous, immediate) drives:
  - state to IDLE
  - sum, cout, busy, done, err, and dig_* to 0
  - all internal registers to 0.
- Latency: with start accepted at edge E, digits are written at edges E+1 … E+DIGITS. done is high in the cycle after E+DIGITS. For DIGITS=4, done follows the start edge by 5 cycles.
- busy: high from after edge E through edge E+DIGITS, i.e. exactly DIGITS cycles. It is low in DONE.
- Back-to-back: start held high in DONE gives a new busy window the next cycle, with no idle gap.
- Reset asserted mid-ADD aborts the operation. No done pulse is produced and the partial sum is discarded (zeroed).
- There is one combinational path (dig_* → external adder → dig_sum/dig_cout → registers). It must close in one clk period.

## Test plan
- DIGITS=4, a=0x1234, b=0x5678, cin=0, start one cycle → busy for 4 cycles; done 5 cycles after the start edge; sum=0x6912, cout=0, err=0.
- a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1. Check the carry ripples through all four digit steps (dig_cin = 1 on digits 1–3).
- a=0x0000, b=0x0000, cin=1 → sum=0x0001, cout=0. Also check a=0x9999, b=0x9999, cin=1 → sum=0x9999, cout=1.
- a=0x12A4, b=0x0001 → done after 5 cycles with err=1, sum=0x0000, cout=0. A following valid start (a=0x0005, b=0x0005) → err=0, sum=0x0010.
- During the busy window, pulse start with different operands → ignored, result unchanged (0x6912 case). Hold start high through DONE → second operation begins immediately; done pulses are 5 cycles apart.
- Assert rst two cycles into ADD → all outputs 0 immediately and no done pulse. After release, a fresh start with 0x0005+0x0007 → sum=0x0012.
